// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control blocks.
package pipe_ctrl_pkg;
    localparam int REG_IDX_W       = 5;
    localparam int MEM_TIMEOUT_DEF = 255;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the ID operands and the EX load.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs_ID,
    input  logic [REG_IDX_W-1:0] rt_ID,
    input  logic                 use_rs_ID,
    input  logic                 use_rt_ID,
    input  logic                 RegWr_EX,
    input  logic                 MemRd_EX,
    input  logic [REG_IDX_W-1:0] wr_addr_EX,
    output logic                 load_use
);
    logic rs_hit;
    logic rt_hit;

    // $0 is hardwired to zero, so a load targeting it never blocks a reader
    assign rs_hit   = use_rs_ID && (rs_ID == wr_addr_EX);
    assign rt_hit   = use_rt_ID && (rt_ID == wr_addr_EX);
    assign load_use = RegWr_EX && MemRd_EX && (wr_addr_EX != '0) && (rs_hit || rt_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer: memory-wait FSM with timeout, branch flush,
// load-use stall, and stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs_ID,
    input  logic [REG_IDX_W-1:0] rt_ID,
    input  logic                 use_rs_ID,
    input  logic                 use_rt_ID,
    input  logic                 RegWr_EX,
    input  logic                 MemRd_EX,
    input  logic [REG_IDX_W-1:0] wr_addr_EX,
    input  logic                 branch_taken_EX,
    input  logic                 MemRd_MEM,
    input  logic                 MemWr_MEM,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 stall_PC,
    output logic                 stall_IFID,
    output logic                 stall_IDEX,
    output logic                 stall_EXMEM,
    output logic                 bubble_IFID,
    output logic                 bubble_IDEX,
    output logic                 bubble_MEMWB,
    output logic                 mem_err,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
);
    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_nxt;
    logic        memop;
    logic        load_use;
    logic        mem_stall;
    logic        timeout;
    logic        flush;

    assign memop = MemRd_MEM || MemWr_MEM;

    load_use_detect u_lud (
        .rs_ID      (rs_ID),
        .rt_ID      (rt_ID),
        .use_rs_ID  (use_rs_ID),
        .use_rt_ID  (use_rt_ID),
        .RegWr_EX   (RegWr_EX),
        .MemRd_EX   (MemRd_EX),
        .wr_addr_EX (wr_addr_EX),
        .load_use   (load_use)
    );

    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        mem_stall    = 1'b0;
        timeout      = 1'b0;
        flush        = 1'b0;
        mem_req      = 1'b0;
        stall_PC     = 1'b0;
        stall_IFID   = 1'b0;
        stall_IDEX   = 1'b0;
        stall_EXMEM  = 1'b0;
        bubble_IFID  = 1'b0;
        bubble_IDEX  = 1'b0;
        bubble_MEMWB = 1'b0;

        if (!rst) begin
            mem_req = memop;
            case (state)
                RUN: begin
                    if (memop && !mem_ready) begin
                        mem_stall = 1'b1;
                        state_nxt = MEM_WAIT;
                        wait_nxt  = 16'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!memop || mem_ready) begin
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end else if (wait_cnt >= TIMEOUT) begin
                        // abandon the access; MEM/WB still gets a bubble
                        timeout   = 1'b1;
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end else begin
                        mem_stall = 1'b1;
                        wait_nxt  = wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            endcase

            if (mem_stall) begin
                stall_PC     = 1'b1;
                stall_IFID   = 1'b1;
                stall_IDEX   = 1'b1;
                stall_EXMEM  = 1'b1;
                bubble_MEMWB = 1'b1;
            end else if (branch_taken_EX) begin
                flush       = 1'b1;
                bubble_IFID = 1'b1;
                bubble_IDEX = 1'b1;
            end else if (load_use) begin
                stall_PC    = 1'b1;
                stall_IFID  = 1'b1;
                bubble_IDEX = 1'b1;
            end

            if (timeout) begin
                bubble_MEMWB = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout) begin
                mem_err <= 1'b1;
            end
            if (stall_PC) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic.
module tb_pipe_hazard_ctrl;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_ID, rt_ID, wr_addr_EX;
    logic        use_rs_ID, use_rt_ID, RegWr_EX, MemRd_EX;
    logic        branch_taken_EX, MemRd_MEM, MemWr_MEM, mem_ready;
    logic        mem_req, stall_PC, stall_IFID, stall_IDEX, stall_EXMEM;
    logic        bubble_IFID, bubble_IDEX, bubble_MEMWB, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
        .RegWr_EX(RegWr_EX), .MemRd_EX(MemRd_EX), .wr_addr_EX(wr_addr_EX),
        .branch_taken_EX(branch_taken_EX), .MemRd_MEM(MemRd_MEM), .MemWr_MEM(MemWr_MEM),
        .mem_ready(mem_ready), .mem_req(mem_req),
        .stall_PC(stall_PC), .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX),
        .stall_EXMEM(stall_EXMEM), .bubble_IFID(bubble_IFID), .bubble_IDEX(bubble_IDEX),
        .bubble_MEMWB(bubble_MEMWB), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ctl = {mem_req, stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, bubble_IFID, bubble_IDEX, bubble_MEMWB}
    typedef struct packed {
        logic [7:0]  ctl;
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // reference: number of stall cycles already spent on the pending access
    int          waited = 0;
    logic        m_err  = 1'b0;
    logic [31:0] m_sc   = '0;
    logic [31:0] m_fc   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic rw, input logic mr,
                         input logic [4:0] wr, input logic br, input logic mrm,
                         input logic mwm, input logic rdy);
        exp_t e;
        logic memop, lu, ms, to;
        @(posedge clk);
        #1;
        rst = r; rs_ID = rs; rt_ID = rt; use_rs_ID = urs; use_rt_ID = urt;
        RegWr_EX = rw; MemRd_EX = mr; wr_addr_EX = wr; branch_taken_EX = br;
        MemRd_MEM = mrm; MemWr_MEM = mwm; mem_ready = rdy;

        e.err = m_err; e.sc = m_sc; e.fc = m_fc; e.ctl = '0;
        if (r) begin
            q.push_back(e);
            waited = 0; m_err = 1'b0; m_sc = '0; m_fc = '0;
        end else begin
            memop = mrm | mwm;
            lu = rw && mr && (wr != 0) && ((urs && rs == wr) || (urt && rt == wr));
            ms = memop && !rdy && (waited < T);
            to = memop && !rdy && (waited >= T);
            e.ctl[7] = memop;
            if (ms)       e.ctl[6:0] = 7'b1111001;
            else if (br)  e.ctl[6:0] = 7'b0000110;
            else if (lu)  e.ctl[6:0] = 7'b1100010;
            if (to) e.ctl[0] = 1'b1;
            q.push_back(e);
            if (e.ctl[6]) m_sc = m_sc + 1;
            if (!ms && br) m_fc = m_fc + 1;
            if (to) m_err = 1'b1;
            waited = ms ? waited + 1 : 0;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("ctl", {24'd0, mem_req, stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
                          bubble_IFID, bubble_IDEX, bubble_MEMWB}, {24'd0, e.ctl});
            check("mem_err", {31'd0, mem_err}, {31'd0, e.err});
            check("stall_cnt", stall_cnt, e.sc);
            check("flush_cnt", flush_cnt, e.fc);
        end
    end

    initial begin
        rst = 1'b1; rs_ID = '0; rt_ID = '0; use_rs_ID = 0; use_rt_ID = 0;
        RegWr_EX = 0; MemRd_EX = 0; wr_addr_EX = '0; branch_taken_EX = 0;
        MemRd_MEM = 0; MemWr_MEM = 0; mem_ready = 0;
        repeat (2) @(posedge clk);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // load-use on rs, then the load sits in MEM and completes at once
        drive(0, 5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0);
        drive(0, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        // load into $0, and a load-use via rt
        drive(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 7, 1, 1, 1, 1, 7, 0, 0, 0, 0);
        // taken branch alone, then with a load-use match
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 5, 0, 1, 0, 1, 1, 5, 1, 0, 0, 0);
        // 3 wait cycles then ready
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        // zero-wait store
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // timeout: T stall cycles, release with bubble, sticky error
        repeat (T + 1) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        idle();
        // stall with a pending branch underneath
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        // reset mid-wait
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

        for (int i = 0; i < 800; i++) begin
            logic r, urs, urt, rw, mr, br, mrm, mwm, rdy;
            logic [4:0] rs, rt, wr;
            r   = ($urandom_range(0, 99) < 2);
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            wr  = 5'($urandom_range(0, 3));
            urs = 1'($urandom_range(0, 1));
            urt = 1'($urandom_range(0, 1));
            rw  = ($urandom_range(0, 99) < 70);
            mr  = ($urandom_range(0, 99) < 50);
            br  = ($urandom_range(0, 99) < 20);
            mrm = ($urandom_range(0, 99) < 35);
            mwm = ($urandom_range(0, 99) < 15);
            rdy = ($urandom_range(0, 99) < 25);
            drive(r, rs, rt, urs, urt, rw, mr, wr, br, mrm, mwm, rdy);
        end

        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
